// File: rtl/ssram_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SSRAM slave between NW write and NR read ports.
// Accepted reads are tagged with their port so returning data is routed back in order.
module ssram_port_arbiter #(
   parameter int unsigned NW        = 3,
   parameter int unsigned NR        = 2,
   parameter int unsigned AW        = 32,
   parameter int unsigned DW        = 32,
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned TAG_DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NW-1:0]    wr_req,
   input  logic [NW*AW-1:0] wr_addr,
   input  logic [NW*DW-1:0] wr_data,
   output logic [NW-1:0]    wr_ready,
   input  logic [NR-1:0]    rd_req,
   input  logic [NR*AW-1:0] rd_addr,
   output logic [NR-1:0]    rd_ready,
   output logic [DW-1:0]    rd_data,
   output logic [NR-1:0]    rd_data_valid,
   output logic [AW-1:0]    av_address,
   output logic [DW-1:0]    av_writedata,
   output logic             av_write,
   output logic             av_read,
   input  logic             av_waitrequest,
   input  logic [DW-1:0]    av_readdata,
   input  logic             av_readdatavalid,
   output logic             rsp_err
);

   localparam int unsigned NS = NW + NR;
   localparam int unsigned SW = (NS > 1) ? $clog2(NS) : 1;
   localparam int unsigned TW = (NR > 1) ? $clog2(NR) : 1;
   localparam int unsigned PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int unsigned CW = $clog2(TAG_DEPTH) + 1;
   localparam int unsigned BW = $clog2(MAX_BURST + 1);

   localparam logic [CW-1:0] TagFull   = CW'(TAG_DEPTH);
   localparam logic [BW-1:0] BurstLast = BW'(MAX_BURST - 1);
   localparam logic [PW-1:0] PtrLast   = PW'(TAG_DEPTH - 1);
   localparam logic [SW-1:0] SlotLast  = SW'(NS - 1);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e          state_q, state_d;
   logic [SW-1:0]   ptr_q, ptr_d;
   logic [SW-1:0]   gnt_q, gnt_d;
   logic [SW-1:0]   sel_idx;
   logic [BW-1:0]   burst_q, burst_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   wptr_q, rptr_q;
   logic [TW-1:0]   tag_mem [TAG_DEPTH];
   logic [TW-1:0]   push_tag;
   logic [NS-1:0]   elig;
   logic            sel_found;
   logic            tag_space;
   logic            accept;
   logic            push;
   logic            pop;
   logic [NR-1:0]   pop_onehot;
   logic [DW-1:0]   rd_data_q;
   logic [NR-1:0]   rd_data_valid_q;
   logic            rsp_err_q;

   assign tag_space = (cnt_q < TagFull);
   assign elig      = {rd_req & {NR{tag_space}}, wr_req};

   // First eligible slot at or above ptr, wrapping past the last slot.
   always_comb begin : rr_search
      int unsigned j;
      j         = 0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int unsigned k = 0; k < NS; k++) begin
         j = k + ptr_q;
         if (j >= NS) begin
            j = j - NS;
         end
         if (!sel_found && elig[j[SW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = j[SW-1:0];
         end
      end
   end

   always_comb begin : av_mux
      av_write     = 1'b0;
      av_read      = 1'b0;
      av_address   = '0;
      av_writedata = '0;
      push_tag     = '0;
      if (state_q == StGrant) begin
         for (int unsigned i = 0; i < NW; i++) begin
            if (gnt_q == SW'(i)) begin
               av_write     = wr_req[i];
               av_address   = wr_addr[i*AW +: AW];
               av_writedata = wr_data[i*DW +: DW];
            end
         end
         for (int unsigned i = 0; i < NR; i++) begin
            if (gnt_q == SW'(NW + i)) begin
               av_read    = rd_req[i];
               av_address = rd_addr[i*AW +: AW];
               push_tag   = TW'(i);
            end
         end
      end
   end

   assign accept = (av_write | av_read) & ~av_waitrequest;
   assign push   = accept & av_read;
   // A return with nothing outstanding is not popped; it only flags rsp_err.
   assign pop    = av_readdatavalid & (cnt_q != '0);

   always_comb begin : ready_dec
      wr_ready = '0;
      rd_ready = '0;
      for (int unsigned i = 0; i < NW; i++) begin
         wr_ready[i] = accept & av_write & (gnt_q == SW'(i));
      end
      for (int unsigned i = 0; i < NR; i++) begin
         rd_ready[i] = accept & av_read & (gnt_q == SW'(NW + i));
      end
   end

   always_comb begin : tag_count
      cnt_d = cnt_q;
      if (push && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!push && pop) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_comb begin : tag_route
      pop_onehot = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         pop_onehot[i] = pop & (tag_mem[rptr_q] == TW'(i));
      end
   end

   always_comb begin : fsm_next
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      burst_d = burst_q;
      case (state_q)
         StIdle: begin
            if (sel_found) begin
               gnt_d   = sel_idx;
               burst_d = '0;
               state_d = StGrant;
               ptr_d   = (sel_idx == SlotLast) ? '0 : sel_idx + SW'(1);
            end
         end
         StGrant: begin
            if (!(av_write || av_read)) begin
               state_d = StIdle;
            end else if (accept) begin
               burst_d = burst_q + BW'(1);
               if ((burst_q == BurstLast) || (av_read && (cnt_d == TagFull))) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StIdle;
         ptr_q           <= '0;
         gnt_q           <= '0;
         burst_q         <= '0;
         cnt_q           <= '0;
         wptr_q          <= '0;
         rptr_q          <= '0;
         rd_data_q       <= '0;
         rd_data_valid_q <= '0;
         rsp_err_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         ptr_q           <= ptr_d;
         gnt_q           <= gnt_d;
         burst_q         <= burst_d;
         cnt_q           <= cnt_d;
         rd_data_valid_q <= pop_onehot;
         if (push) begin
            wptr_q <= (wptr_q == PtrLast) ? '0 : wptr_q + PW'(1);
         end
         if (pop) begin
            rptr_q    <= (rptr_q == PtrLast) ? '0 : rptr_q + PW'(1);
            rd_data_q <= av_readdata;
         end
         if (av_readdatavalid && !pop) begin
            rsp_err_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wptr_q] <= push_tag;
      end
   end

   assign rd_data       = rd_data_q;
   assign rd_data_valid = rd_data_valid_q;
   assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_ssram_port_arbiter.sv
// Self-checking bench for ssram_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (owner/burst counters and a tag queue).
module tb_ssram_port_arbiter;

   localparam int NW = 3;
   localparam int NR = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MB = 4;
   localparam int TD = 16;
   localparam int NS = NW + NR;

   logic             clk = 1'b0;
   logic             rst;
   logic [NW-1:0]    wr_req;
   logic [NW*AW-1:0] wr_addr;
   logic [NW*DW-1:0] wr_data;
   logic [NW-1:0]    wr_ready;
   logic [NR-1:0]    rd_req;
   logic [NR*AW-1:0] rd_addr;
   logic [NR-1:0]    rd_ready;
   logic [DW-1:0]    rd_data;
   logic [NR-1:0]    rd_data_valid;
   logic [AW-1:0]    av_address;
   logic [DW-1:0]    av_writedata;
   logic             av_write;
   logic             av_read;
   logic             av_waitrequest;
   logic [DW-1:0]    av_readdata;
   logic             av_readdatavalid;
   logic             rsp_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ssram_port_arbiter #(
      .NW(NW), .NR(NR), .AW(AW), .DW(DW), .MAX_BURST(MB), .TAG_DEPTH(TD)
   ) dut (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
      .rd_data(rd_data), .rd_data_valid(rd_data_valid),
      .av_address(av_address), .av_writedata(av_writedata),
      .av_write(av_write), .av_read(av_read), .av_waitrequest(av_waitrequest),
      .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
      .rsp_err(rsp_err)
   );

   function automatic logic [DW-1:0] slave_f(input logic [AW-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_req = '0; wr_addr = '0; wr_data = '0;
      rd_req = '0; rd_addr = '0;
      av_waitrequest = 1'b0; av_readdata = '0; av_readdatavalid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      wr_req = '1;
      rd_req = '1;
      cyc();
      cyc();
      @(negedge clk);
      n_tests++;
      if ({av_write, av_read, wr_ready, rd_ready, rd_data_valid, rsp_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got w%b r%b wrdy%b rrdy%b v%b err%b, want all 0",
                  av_write, av_read, wr_ready, rd_ready, rd_data_valid, rsp_err);
      end
      n_tests++;
      if (av_address !== '0) begin
         n_fail++; $display("FAIL reset_addr: got %h want 0", av_address);
      end
      n_tests++;
      if (av_writedata !== '0) begin
         n_fail++; $display("FAIL reset_wdata: got %h want 0", av_writedata);
      end
      n_tests++;
      if (rd_data !== '0) begin
         n_fail++; $display("FAIL reset_rdata: got %h want 0", rd_data);
      end
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_single_write();
      int pulses;
      do_reset();
      wr_req = 3'b001;
      wr_addr[0 +: AW] = 32'h0800_0010;
      wr_data[0 +: DW] = 32'hCAFE_0001;
      @(negedge clk);
      n_tests++;
      if (av_write !== 1'b0 || wr_ready !== 3'b000) begin
         n_fail++; $display("FAIL single_latency: got w%b rdy%b want w0 rdy000", av_write, wr_ready);
      end
      cyc();
      @(negedge clk);
      n_tests++;
      if (av_write !== 1'b1 || wr_ready !== 3'b001) begin
         n_fail++; $display("FAIL single_cmd: got w%b rdy%b want w1 rdy001", av_write, wr_ready);
      end
      n_tests++;
      if (av_address !== 32'h0800_0010 || av_writedata !== 32'hCAFE_0001) begin
         n_fail++; $display("FAIL single_bus: got %h/%h want 08000010/cafe0001", av_address, av_writedata);
      end
      cyc();
      wr_req = '0;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         pulses += int'(wr_ready[0]) + int'(av_write);
         cyc();
      end
      n_tests++;
      if (pulses != 0) begin
         n_fail++; $display("FAIL single_after: got %0d extra cmds want 0", pulses);
      end
      // Back in IDLE: a new request is granted one cycle later.
      wr_req = 3'b100;
      @(negedge clk);
      cyc();
      @(negedge clk);
      n_tests++;
      if (wr_ready !== 3'b100) begin
         n_fail++; $display("FAIL single_regrant: got %b want 100", wr_ready);
      end
      cyc();
      idle_inputs();
   endtask

   task automatic test_round_robin();
      logic [NS-1:0] exp_rdy;
      logic [NS-1:0] obs;
      int slot;
      do_reset();
      for (int i = 0; i < NW; i++) wr_addr[i*AW +: AW] = 32'h1000_0000 + 32'(i * 16);
      for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = 32'h1000_0000 + 32'((NW + i) * 16);
      wr_req = '1;
      rd_req = '1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         slot = (c / 5) % NS;
         exp_rdy = ((c % 5) == 0) ? '0 : (NS'(1) << slot);
         obs = {rd_ready, wr_ready};
         n_tests++;
         if (obs !== exp_rdy) begin
            n_fail++; $display("FAIL rr_ready c%0d: got %b want %b", c, obs, exp_rdy);
         end
         if (exp_rdy != '0) begin
            n_tests++;
            if (av_address !== 32'h1000_0000 + 32'(slot * 16)) begin
               n_fail++; $display("FAIL rr_addr c%0d: got %h want %h", c, av_address,
                                  32'h1000_0000 + 32'(slot * 16));
            end
         end
         cyc();
      end
      idle_inputs();
   endtask

   task automatic test_wait_stall();
      int  e_k;
      bit  e_rdy, e_cmd;
      do_reset();
      e_k = 0;
      wr_req = 3'b010;
      wr_addr[AW +: AW] = 32'h2000_0000;
      wr_data[DW +: DW] = 32'hA000_0000;
      for (int c = 0; c < 12; c++) begin
         av_waitrequest = (c >= 3 && c <= 7);
         @(negedge clk);
         e_cmd = (c >= 1 && c <= 9) || c == 11;
         e_rdy = (c == 1 || c == 2 || c == 8 || c == 9 || c == 11);
         n_tests++;
         if (wr_ready !== (e_rdy ? 3'b010 : 3'b000) || av_write !== e_cmd) begin
            n_fail++; $display("FAIL stall_ctrl c%0d: got rdy%b w%b want rdy%b w%b",
                               c, wr_ready, av_write, e_rdy ? 3'b010 : 3'b000, e_cmd);
         end
         if (e_cmd) begin
            n_tests++;
            if (av_address !== 32'h2000_0000 + 32'(e_k) || av_writedata !== 32'hA000_0000 + 32'(e_k))
            begin
               n_fail++; $display("FAIL stall_bus c%0d: got %h/%h want %h/%h", c, av_address,
                                  av_writedata, 32'h2000_0000 + 32'(e_k), 32'hA000_0000 + 32'(e_k));
            end
         end
         if (e_rdy) e_k++;
         if (wr_ready[1]) begin
            cyc();
            wr_addr[AW +: AW] = wr_addr[AW +: AW] + 1;
            wr_data[DW +: DW] = wr_data[DW +: DW] + 1;
         end else begin
            cyc();
         end
      end
      idle_inputs();
   endtask

   task automatic test_read_routing();
      logic [NR-1:0] e_rrdy, e_v;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c == 0) begin rd_req = 2'b01; rd_addr[0 +: AW] = 32'h0000_0A00; end
         if (c == 2) begin rd_req = 2'b10; rd_addr[AW +: AW] = 32'h0000_0B00; end
         if (c == 5) rd_req = 2'b00;
         av_readdatavalid = (c == 4 || c == 7);
         av_readdata = (c == 4) ? 32'hDA7A_000A : (c == 7) ? 32'hDA7A_000B : 32'hFFFF_FFFF;
         @(negedge clk);
         e_rrdy = (c == 1) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00;
         e_v    = (c == 5) ? 2'b01 : (c == 8) ? 2'b10 : 2'b00;
         n_tests++;
         if (rd_ready !== e_rrdy) begin
            n_fail++; $display("FAIL route_rdy c%0d: got %b want %b", c, rd_ready, e_rrdy);
         end
         n_tests++;
         if (rd_data_valid !== e_v) begin
            n_fail++; $display("FAIL route_valid c%0d: got %b want %b", c, rd_data_valid, e_v);
         end
         if (c == 5 || c == 8) begin
            n_tests++;
            if (rd_data !== ((c == 5) ? 32'hDA7A_000A : 32'hDA7A_000B)) begin
               n_fail++; $display("FAIL route_data c%0d: got %h", c, rd_data);
            end
         end
         if (c == 1 || c == 4) begin
            n_tests++;
            if (av_address !== ((c == 1) ? 32'h0000_0A00 : 32'h0000_0B00)) begin
               n_fail++; $display("FAIL route_addr c%0d: got %h", c, av_address);
            end
         end
         cyc();
      end
      n_tests++;
      if (rsp_err !== 1'b0) begin
         n_fail++; $display("FAIL route_err: got %b want 0", rsp_err);
      end
      idle_inputs();
   endtask

   task automatic test_tag_full();
      int rd_acc, wr_late, rd_acc2, vcnt;
      logic [NR-1:0] vbits;
      logic [DW-1:0] vdat;
      do_reset();
      wr_req = 3'b001;
      wr_addr[0 +: AW] = 32'h3000_0000;
      rd_req = 2'b11;
      rd_addr = {32'h3100_0004, 32'h3100_0000};
      rd_acc = 0; wr_late = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         rd_acc += $countones(rd_ready);
         if (rd_acc >= TD && wr_ready[0]) wr_late++;
         cyc();
      end
      n_tests++;
      if (rd_acc != TD) begin
         n_fail++; $display("FAIL tagfull_reads: got %0d want %0d", rd_acc, TD);
      end
      n_tests++;
      if (wr_late == 0) begin
         n_fail++; $display("FAIL tagfull_writes: got %0d writes after full want >0", wr_late);
      end
      av_readdatavalid = 1'b1;
      av_readdata = 32'h7777_0001;
      @(negedge clk);
      cyc();
      av_readdatavalid = 1'b0;
      rd_acc2 = 0; vcnt = 0; vbits = '0; vdat = '0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         rd_acc2 += $countones(rd_ready);
         if (rd_data_valid != '0) begin vcnt++; vbits = rd_data_valid; vdat = rd_data; end
         cyc();
      end
      n_tests++;
      if (rd_acc2 != 1) begin
         n_fail++; $display("FAIL tagfull_reenable: got %0d reads want 1", rd_acc2);
      end
      n_tests++;
      if (vcnt != 1 || vbits !== 2'b01 || vdat !== 32'h7777_0001) begin
         n_fail++; $display("FAIL tagfull_return: got n%0d v%b d%h want n1 v01 d77770001",
                            vcnt, vbits, vdat);
      end
      n_tests++;
      if (rsp_err !== 1'b0) begin
         n_fail++; $display("FAIL tagfull_err: got %b want 0", rsp_err);
      end
      idle_inputs();
   endtask

   task automatic test_spurious();
      do_reset();
      av_readdatavalid = 1'b1;
      av_readdata = 32'h0000_1234;
      @(negedge clk);
      n_tests++;
      if (rsp_err !== 1'b0) begin
         n_fail++; $display("FAIL spur_early: got %b want 0", rsp_err);
      end
      cyc();
      av_readdatavalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_tests++;
         if (rsp_err !== 1'b1 || rd_data_valid !== '0) begin
            n_fail++; $display("FAIL spur_sticky c%0d: got err%b v%b want err1 v00",
                               c, rsp_err, rd_data_valid);
         end
         cyc();
      end
      rst = 1'b1;
      cyc();
      @(negedge clk);
      n_tests++;
      if (rsp_err !== 1'b0) begin
         n_fail++; $display("FAIL spur_clear: got %b want 0", rsp_err);
      end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_random();
      int            w_left[NW];
      int            r_left[NR];
      int            m_owner, m_ptr, m_cnt, nb, s, idx, p;
      bit            found, ok;
      int            m_tags[$];
      logic [NR-1:0] m_rdv;
      logic [DW-1:0] m_rdata;
      logic          m_err;
      logic [DW-1:0] rsp_dat[$];
      int            rsp_due[$];
      int            exp_port[$];
      logic [DW-1:0] exp_dat[$];
      logic [NW-1:0] w_pop;
      logic [NR-1:0] r_pop;
      logic          e_w, e_r, acc;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_data;
      logic [NW-1:0] e_wrdy;
      logic [NR-1:0] e_rrdy;

      do_reset();
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_rdv = '0; m_rdata = '0; m_err = 1'b0;
      w_pop = '0; r_pop = '0;
      for (int i = 0; i < NW; i++) w_left[i] = 0;
      for (int i = 0; i < NR; i++) r_left[i] = 0;

      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NW; i++) begin
            if (w_pop[i]) begin
               w_left[i]--;
               wr_addr[i*AW +: AW] = $urandom; wr_data[i*DW +: DW] = $urandom;
            end
            if (w_left[i] == 0 && n < 2800 && $urandom_range(0, 5) == 0) begin
               w_left[i] = $urandom_range(1, 7);
               wr_addr[i*AW +: AW] = $urandom; wr_data[i*DW +: DW] = $urandom;
            end
            wr_req[i] = (w_left[i] > 0);
         end
         for (int i = 0; i < NR; i++) begin
            if (r_pop[i]) begin
               r_left[i]--;
               rd_addr[i*AW +: AW] = $urandom;
            end
            if (r_left[i] == 0 && n < 2800 && $urandom_range(0, 3) == 0) begin
               r_left[i] = $urandom_range(1, 9);
               rd_addr[i*AW +: AW] = $urandom;
            end
            rd_req[i] = (r_left[i] > 0);
         end
         av_waitrequest = ($urandom_range(0, 3) == 0);
         if (rsp_due.size() > 0 && rsp_due[0] <= n && $urandom_range(0, 2) != 0) begin
            av_readdatavalid = 1'b1;
            av_readdata = rsp_dat.pop_front();
            void'(rsp_due.pop_front());
         end else begin
            av_readdatavalid = 1'b0;
            av_readdata = $urandom;
         end

         @(negedge clk);
         e_w = 1'b0; e_r = 1'b0; e_addr = '0; e_data = '0;
         if (m_owner >= 0 && m_owner < NW) begin
            e_w = wr_req[m_owner];
            e_addr = wr_addr[m_owner*AW +: AW];
            e_data = wr_data[m_owner*DW +: DW];
         end else if (m_owner >= NW) begin
            e_r = rd_req[m_owner-NW];
            e_addr = rd_addr[(m_owner-NW)*AW +: AW];
         end
         acc = (e_w | e_r) & ~av_waitrequest;
         e_wrdy = (acc && e_w) ? (NW'(1) << m_owner) : '0;
         e_rrdy = (acc && e_r) ? (NR'(1) << (m_owner - NW)) : '0;

         n_tests++;
         if (av_write !== e_w || av_read !== e_r || wr_ready !== e_wrdy || rd_ready !== e_rrdy)
         begin
            n_fail++; $display("FAIL rand_ctrl n%0d: got w%b r%b %b/%b want w%b r%b %b/%b", n,
                               av_write, av_read, wr_ready, rd_ready, e_w, e_r, e_wrdy, e_rrdy);
         end
         if (e_w || e_r) begin
            n_tests++;
            if (av_address !== e_addr || (e_w && av_writedata !== e_data)) begin
               n_fail++; $display("FAIL rand_bus n%0d: got %h/%h want %h/%h", n,
                                  av_address, av_writedata, e_addr, e_data);
            end
         end
         n_tests++;
         if (rd_data_valid !== m_rdv || rsp_err !== m_err) begin
            n_fail++; $display("FAIL rand_ret n%0d: got v%b err%b want v%b err%b", n,
                               rd_data_valid, rsp_err, m_rdv, m_err);
         end
         if (m_rdv != '0) begin
            n_tests++;
            if (rd_data !== m_rdata) begin
               n_fail++; $display("FAIL rand_rdata n%0d: got %h want %h", n, rd_data, m_rdata);
            end
         end
         if (rd_data_valid != '0) begin
            p = 0;
            for (int q = NR - 1; q >= 0; q--) if (rd_data_valid[q]) p = q;
            idx = -1;
            for (int e = exp_port.size() - 1; e >= 0; e--) if (exp_port[e] == p) idx = e;
            n_tests++;
            if (idx < 0) begin
               n_fail++; $display("FAIL rand_port n%0d: port %0d got %h with nothing issued",
                                  n, p, rd_data);
            end else begin
               if (rd_data !== exp_dat[idx]) begin
                  n_fail++; $display("FAIL rand_port n%0d: port %0d got %h want %h",
                                     n, p, rd_data, exp_dat[idx]);
               end
               exp_port.delete(idx);
               exp_dat.delete(idx);
            end
         end

         w_pop = wr_ready;
         r_pop = rd_ready;
         if (av_read && !av_waitrequest) begin
            rsp_dat.push_back(slave_f(av_address));
            rsp_due.push_back(n + $urandom_range(1, 10));
         end
         for (int q = 0; q < NR; q++) begin
            if (rd_ready[q]) begin
               exp_port.push_back(q);
               exp_dat.push_back(slave_f(rd_addr[q*AW +: AW]));
            end
         end

         nb = m_tags.size();
         m_rdv = '0;
         if (av_readdatavalid) begin
            if (nb > 0) begin
               idx = m_tags.pop_front();
               m_rdv = NR'(1) << idx;
               m_rdata = av_readdata;
            end else begin
               m_err = 1'b1;
            end
         end
         if (acc && e_r) m_tags.push_back(m_owner - NW);
         if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < NS; k++) begin
               s = (m_ptr + k) % NS;
               ok = (s < NW) ? wr_req[s] : (rd_req[s-NW] && nb < TD);
               if (!found && ok) begin
                  found = 1'b1;
                  idx = s;
               end
            end
            if (found) begin
               m_owner = idx; m_cnt = 0; m_ptr = (idx + 1) % NS;
            end
         end else if (!(e_w || e_r)) begin
            m_owner = -1;
         end else if (acc) begin
            m_cnt++;
            if (m_cnt == MB) m_owner = -1;
            else if (m_owner >= NW && m_tags.size() == TD) m_owner = -1;
         end
         cyc();
      end
      n_tests++;
      if (exp_port.size() != 0 || m_tags.size() != 0) begin
         n_fail++; $display("FAIL rand_drain: got %0d undelivered reads, model %0d outstanding, want 0",
                            exp_port.size(), m_tags.size());
      end
      idle_inputs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single_write();
      test_round_robin();
      test_wait_stall();
      test_read_routing();
      test_tag_full();
      test_spurious();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ssram_port_arbiter.md
# ssram_port_arbiter

Single-clock arbiter that shares the SSRAM controller's Avalon-MM slave port between NW write requesters (camera store, optical-flow writeback, CNN writeback) and NR read requesters (optical-flow fetch, CNN fetch). Requests are granted round-robin with bounded bursts. Accepted reads are tagged so that returning read data goes back to the port that issued it. The block sits between the per-client clock-crossing FIFOs and the SSRAM controller, and runs entirely in the controller's Avalon clock domain.

## Interface
Parameters:
- NW, 3, number of write ports (slots 0..NW-1)
- NR, 2, number of read ports (slots NW..NW+NR-1)
- AW, 32, address width
- DW, 32, data width
- MAX_BURST, 16, maximum accepted transfers per grant (≥1)
- TAG_DEPTH, 16, maximum outstanding reads; power of two

Ports:
- clk  in  1  Avalon clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_req  in  NW  write request per port
- wr_addr  in  NW*AW  packed addresses; port i at [i*AW +: AW]
- wr_data  in  NW*DW  packed write data
- wr_ready  out  NW  transfer accepted this cycle (port pops its FIFO)
- rd_req  in  NR  read request per port
- rd_addr  in  NR*AW  packed read addresses
- rd_ready  out  NR  read command accepted this cycle
- rd_data  out  DW  shared read-return data (registered)
- rd_data_valid  out  NR  one-hot, rd_data belongs to this port
- av_address  out  AW  to SSRAM controller
- av_writedata  out  DW
- av_write  out  1
- av_read  out  1
- av_waitrequest  in  1
- av_readdata  in  DW
- av_readdatavalid  in  1
- rsp_err  out  1  sticky: readdatavalid arrived with no outstanding tag

## Operation
- Slot vector S = {rd_req, wr_req}, NW+NR bits. A read slot is eligible only while outstanding count < TAG_DEPTH. A write slot is always eligible.
- States:
  - IDLE: if any slot is eligible, select the first eligible slot searching upward from ptr with wrap. Register it as gnt_idx, clear burst count, go to GRANT. ptr then becomes gnt_idx+1 mod (NW+NR).
  - GRANT: drive the granted port onto av_*: av_write = wr_req[gnt] for a write slot, av_read = rd_req[gnt] for a read slot, with the address and data muxed from that port.
- Accept = (av_write|av_read) && !av_waitrequest. The ready bit of the granted port equals accept. All other ready bits are 0.
- Each accept increments burst count. GRANT→IDLE on the cycle where:
  - the granted request is low, or
  - an accept brings the count to MAX_BURST, or
  - a read slot has no tag space left after this accept.
- Tag FIFO (TAG_DEPTH × clog2(NR)):
  - Push the read-port index on each read accept.
  - Pop on av_readdatavalid. The next cycle shows rd_data = av_readdata and rd_data_valid[tag] = 1.
  - Push and pop in the same cycle leave the count unchanged.
  - Outstanding count width is clog2(TAG_DEPTH)+1.
- av_readdatavalid with an empty FIFO: no pop, no valid pulse, and rsp_err is set until reset.
- Writes never wait on read returns. Ordering is preserved per port only.
- Reset mid-burst: the grant is dropped immediately and the tag FIFO is flushed. Read data returned for pre-reset commands raises rsp_err. This is accepted, because the system resets the controller together with this block.

## Timing
- Reset values: av_write=0, av_read=0, av_address=0, av_writedata=0, all ready=0, rd_data_valid=0, rd_data=0, rsp_err=0, ptr=0, state IDLE, FIFO empty.
- Request → first av command: 1 cycle. A request seen in IDLE at edge t appears on av_* from edge t+1.
- Between consecutive grants there is exactly one IDLE bubble cycle.
- While in GRANT with waitrequest low, throughput is 1 transfer per cycle.
- av_* outputs are combinational from gnt_idx and the port inputs. Ports must hold addr/data stable while req is high and ready is low (FIFO show-ahead semantics).
- av_readdatavalid → rd_data_valid: 1 cycle, registered.

## Test plan
- Single write: wr_req[0]=1 for 1 word at addr 0x0800_0010. Expect av_write on the cycle after req, wr_ready[0] pulses once, then the block returns to IDLE.
- Round robin: all ports request continuously, MAX_BURST=4.
  - Expect grant order 0,1,2,3,4,0… with exactly 4 accepts each and one bubble between grants.
- Waitrequest stall: hold av_waitrequest=1 for 5 cycles mid-burst.
  - Expect stable av_address/av_writedata, ready=0, and no burst-count advance during the stall.
- Read routing: port 3 reads A, then port 4 reads B; the slave returns dA then dB with a latency of 3.
  - Expect rd_data_valid=01 with dA, then 10 with dB, each 1 cycle after readdatavalid.
- Tag full: TAG_DEPTH=16, slave withholds data.
  - After 16 read accepts, rd_ready stays 0 and write ports are still granted.
  - One readdatavalid re-enables exactly one read accept.
- Spurious response: pulse av_readdatavalid with no outstanding reads. Expect rsp_err=1 until rst, and no rd_data_valid pulse.
